// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack ALU: op codes, FSM state encoding
// and default sizing.
package rpn_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Command codes carried on the op input
    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_DUP  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    // Control FSM: either accepting commands or running a multiply
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/rpn_shift_mul.sv
// Sequential shift-add multiplier. One partial-product step per cycle,
// DATA_W steps in total; only the low DATA_W bits of the product are kept.
// done is asserted combinationally during the final step, with product
// already holding the finished value, so the caller can commit it on that edge.
module rpn_shift_mul #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int STEP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_next;
    logic [STEP_W-1:0] step_reg;
    logic              busy_reg;

    // Accumulator after adding the current partial product
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    assign busy    = busy_reg;
    assign done    = busy_reg && (step_reg == STEP_W'(DATA_W - 1));
    assign product = acc_next;

    // Latch operands on start, then shift the multiplicand left and the
    // multiplier right once per step until the last step retires
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg   <= 1'b0;
            step_reg   <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start && !busy_reg) begin
            busy_reg   <= 1'b1;
            step_reg   <= '0;
            acc_reg    <= '0;
            mcand_reg  <= a;
            mplier_reg <= b;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            step_reg   <= step_reg + STEP_W'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rpn_stack_alu.sv
// Operand stack and arithmetic core of the RPN calculator. Accepts one
// command per valid/ready handshake; everything except MUL completes on the
// accepting edge. MUL hands the top two entries to the shift-add multiplier
// and stalls op_ready until the product is written back.
module rpn_stack_alu
    import rpn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              op_valid,
    input  logic [2:0]        op,
    output logic              op_ready,
    output logic [DATA_W-1:0] top,
    output logic [DATA_W-1:0] second,
    output logic [CNT_W-1:0]  depth,
    output logic              carry,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] stack_mem [DEPTH];

    logic [CNT_W-1:0]  depth_reg, depth_next;
    logic              carry_reg, carry_next;
    logic              err_ovf_reg, err_ovf_next;
    logic              err_unf_reg, err_unf_next;
    logic [0:0]        state_reg, state_next;

    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;

    logic [PTR_W-1:0]  ptr_free, ptr_top, ptr_second;
    logic              is_empty, is_full, has_two, accept;
    logic [DATA_W:0]   sum_ext, diff_ext;

    // Pointer arithmetic wraps in PTR_W bits; a full stack (depth==DEPTH)
    // yields ptr_free==0 and ptr_top==DEPTH-1 as required.
    assign ptr_free   = depth_reg[PTR_W-1:0];
    assign ptr_top    = ptr_free - PTR_W'(1);
    assign ptr_second = ptr_free - PTR_W'(2);

    assign is_empty = (depth_reg == '0);
    assign is_full  = (depth_reg == CNT_W'(DEPTH));
    assign has_two  = (depth_reg >= CNT_W'(2));

    assign top    = is_empty ? '0 : stack_mem[ptr_top];
    assign second = has_two  ? stack_mem[ptr_second] : '0;
    assign depth  = depth_reg;
    assign carry  = carry_reg;
    assign err_ovf = err_ovf_reg;
    assign err_unf = err_unf_reg;

    assign op_ready = (state_reg == ST_IDLE) && !mul_busy;
    assign accept   = op_valid && op_ready;

    // a = second, b = top; bit DATA_W is carry for ADD and borrow for SUB
    assign sum_ext  = {1'b0, second} + {1'b0, top};
    assign diff_ext = {1'b0, second} - {1'b0, top};

    rpn_shift_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (second),
        .b       (top),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Command decode: next stack pointer, flags, FSM state and the single
    // stack write port. Faulting commands only raise their sticky flag.
    always_comb begin
        depth_next   = depth_reg;
        carry_next   = carry_reg;
        err_ovf_next = err_ovf_reg;
        err_unf_next = err_unf_reg;
        state_next   = state_reg;
        wr_en        = 1'b0;
        wr_addr      = ptr_free;
        wr_data      = din;
        mul_start    = 1'b0;

        if (state_reg == ST_MUL) begin
            if (mul_done) begin
                wr_en      = 1'b1;
                wr_addr    = ptr_second;
                wr_data    = mul_product;
                depth_next = depth_reg - CNT_W'(1);
                state_next = ST_IDLE;
            end
        end else if (accept) begin
            case (op)
                OP_PUSH: begin
                    if (is_full) begin
                        err_ovf_next = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        depth_next = depth_reg + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        err_unf_next = 1'b1;
                    end else begin
                        depth_next = depth_reg - CNT_W'(1);
                    end
                end
                OP_DUP: begin
                    if (is_empty) begin
                        err_unf_next = 1'b1;
                    end else if (is_full) begin
                        err_ovf_next = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        wr_data    = top;
                        depth_next = depth_reg + CNT_W'(1);
                    end
                end
                OP_MUL: begin
                    if (!has_two) begin
                        err_unf_next = 1'b1;
                    end else begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end
                end
                default: begin
                    // ADD, SUB, AND, OR: result replaces second, stack shrinks
                    if (!has_two) begin
                        err_unf_next = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        wr_addr    = ptr_second;
                        depth_next = depth_reg - CNT_W'(1);
                        case (op)
                            OP_ADD: begin
                                wr_data    = sum_ext[DATA_W-1:0];
                                carry_next = sum_ext[DATA_W];
                            end
                            OP_SUB: begin
                                wr_data    = diff_ext[DATA_W-1:0];
                                carry_next = diff_ext[DATA_W];
                            end
                            OP_AND:  wr_data = second & top;
                            default: wr_data = second | top;
                        endcase
                    end
                end
            endcase
        end
    end

    // Control and flag registers; reset overrides any command in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_reg   <= '0;
            carry_reg   <= 1'b0;
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
            state_reg   <= ST_IDLE;
        end else begin
            depth_reg   <= depth_next;
            carry_reg   <= carry_next;
            err_ovf_reg <= err_ovf_next;
            err_unf_reg <= err_unf_next;
            state_reg   <= state_next;
        end
    end

    // Stack storage: contents are irrelevant after reset because depth hides them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rpn_stack_alu.sv
// Self-checking bench for rpn_stack_alu: directed scenarios from the test
// plan plus a randomized command stream checked against a queue-based model.
module tb_rpn_stack_alu;
    import rpn_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] din;
    logic              op_valid;
    logic [2:0]        op;
    logic              op_ready;
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] second;
    logic [CNT_W-1:0]  depth;
    logic              carry;
    logic              err_ovf;
    logic              err_unf;

    int n_cmp = 0;
    int n_bad = 0;
    int n_timeouts = 0;

    // Reference model: the stack as a queue of integers, plus flags
    int stk[$];
    bit m_carry, m_ovf, m_unf;

    always #5 clk = ~clk;

    rpn_stack_alu #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .op_valid (op_valid),
        .op       (op),
        .op_ready (op_ready),
        .top      (top),
        .second   (second),
        .depth    (depth),
        .carry    (carry),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    task automatic model_reset();
        stk.delete();
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_op(input logic [2:0] o, input int d);
        int a, b, r;
        case (o)
            OP_PUSH: if (stk.size() == DEPTH) m_ovf = 1'b1; else stk.push_back(d);
            OP_POP:  if (stk.size() == 0) m_unf = 1'b1; else void'(stk.pop_back());
            OP_DUP: begin
                if (stk.size() == 0) m_unf = 1'b1;
                else if (stk.size() == DEPTH) m_ovf = 1'b1;
                else stk.push_back(stk[stk.size()-1]);
            end
            default: begin
                if (stk.size() < 2) begin
                    m_unf = 1'b1;
                end else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    case (o)
                        OP_ADD: begin r = a + b; m_carry = (r > 255); end
                        OP_SUB: begin r = a - b; m_carry = (b > a); end
                        OP_AND: r = a & b;
                        OP_OR:  r = a | b;
                        default: r = a * b;
                    endcase
                    stk.push_back(r & 255);
                end
            end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        op_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one command and hold it until the core takes it
    task automatic issue(input logic [2:0] o, input logic [7:0] d);
        int waited = 0;
        @(negedge clk);
        op = o;
        din = d;
        op_valid = 1'b1;
        while (!op_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) n_timeouts++;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = 3'($urandom);
        din = 8'($urandom);
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (!op_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) n_timeouts++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        op_valid = 1'b1;
        op = OP_PUSH;
        din = 8'h77;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        op_valid = 1'b0;
        n_cmp++;
        if ({top, second, depth, carry, err_ovf, err_unf, op_ready} !== {8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset: got top=%0d second=%0d depth=%0d carry=%0d ovf=%0d unf=%0d ready=%0d expected 0 0 0 0 0 0 1",
                     top, second, depth, carry, err_ovf, err_unf, op_ready);
        end
        $display("reset: top=%0d depth=%0d ready=%0d", top, depth, op_ready);
    endtask

    task automatic test_add();
        do_reset();
        issue(OP_PUSH, 8'd3);
        issue(OP_PUSH, 8'd5);
        n_cmp++;
        if ({top, second, depth} !== {8'd5, 8'd3, 4'd2}) begin
            n_bad++;
            $display("FAIL push_two: got top=%0d second=%0d depth=%0d expected 5 3 2", top, second, depth);
        end
        issue(OP_ADD, 8'd0);
        n_cmp++;
        if ({top, depth, carry} !== {8'd8, 4'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL add: got top=%0d depth=%0d carry=%0d expected 8 1 0", top, depth, carry);
        end
        $display("add 3+5: top=%0d depth=%0d carry=%0d", top, depth, carry);
    endtask

    task automatic test_wrap();
        do_reset();
        issue(OP_PUSH, 8'd200);
        issue(OP_PUSH, 8'd100);
        issue(OP_ADD, 8'd0);
        n_cmp++;
        if ({top, depth, carry} !== {8'h2C, 4'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL add_wrap: got top=%0d depth=%0d carry=%0d expected 44 1 1", top, depth, carry);
        end
        $display("add 200+100: top=%0d carry=%0d", top, carry);
    endtask

    task automatic test_sub();
        do_reset();
        issue(OP_PUSH, 8'd3);
        issue(OP_PUSH, 8'd5);
        issue(OP_SUB, 8'd0);
        n_cmp++;
        if ({top, depth, carry} !== {8'hFE, 4'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_borrow: got top=%0h depth=%0d carry=%0d expected fe 1 1", top, depth, carry);
        end
        $display("sub 3-5: top=%0h carry=%0d", top, carry);
    endtask

    task automatic test_and_or();
        do_reset();
        issue(OP_PUSH, 8'hF0);
        issue(OP_PUSH, 8'h3C);
        issue(OP_AND, 8'd0);
        n_cmp++;
        if ({top, depth} !== {8'h30, 4'd1}) begin
            n_bad++;
            $display("FAIL and: got top=%0h depth=%0d expected 30 1", top, depth);
        end
        issue(OP_PUSH, 8'h0F);
        issue(OP_OR, 8'd0);
        n_cmp++;
        if ({top, depth} !== {8'h3F, 4'd1}) begin
            n_bad++;
            $display("FAIL or: got top=%0h depth=%0d expected 3f 1", top, depth);
        end
        $display("and/or: top=%0h depth=%0d", top, depth);
    endtask

    task automatic test_underflow();
        do_reset();
        issue(OP_POP, 8'd0);
        issue(OP_ADD, 8'd0);
        n_cmp++;
        if ({depth, err_unf, err_ovf} !== {4'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL underflow: got depth=%0d unf=%0d ovf=%0d expected 0 1 0", depth, err_unf, err_ovf);
        end
        issue(OP_PUSH, 8'd7);
        n_cmp++;
        if ({top, depth, err_unf} !== {8'd7, 4'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL underflow_sticky: got top=%0d depth=%0d unf=%0d expected 7 1 1", top, depth, err_unf);
        end
        $display("underflow: depth=%0d unf=%0d", depth, err_unf);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 7; i++) issue(OP_PUSH, 8'(i));
        n_cmp++;
        if ({depth, err_ovf} !== {4'd7, 1'b0}) begin
            n_bad++;
            $display("FAIL depth7: got depth=%0d ovf=%0d expected 7 0", depth, err_ovf);
        end
        issue(OP_PUSH, 8'd8);
        n_cmp++;
        if ({top, second, depth, err_ovf} !== {8'd8, 8'd7, 4'd8, 1'b0}) begin
            n_bad++;
            $display("FAIL full: got top=%0d second=%0d depth=%0d ovf=%0d expected 8 7 8 0", top, second, depth, err_ovf);
        end
        issue(OP_PUSH, 8'd9);
        n_cmp++;
        if ({top, second, depth, err_ovf} !== {8'd8, 8'd7, 4'd8, 1'b1}) begin
            n_bad++;
            $display("FAIL push_full: got top=%0d second=%0d depth=%0d ovf=%0d expected 8 7 8 1", top, second, depth, err_ovf);
        end
        issue(OP_DUP, 8'd0);
        n_cmp++;
        if ({top, second, depth, err_ovf, err_unf} !== {8'd8, 8'd7, 4'd8, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL dup_full: got top=%0d second=%0d depth=%0d ovf=%0d unf=%0d expected 8 7 8 1 0",
                     top, second, depth, err_ovf, err_unf);
        end
        $display("overflow: depth=%0d top=%0d ovf=%0d", depth, top, err_ovf);
    endtask

    task automatic test_mul_timing();
        int low = 0;
        do_reset();
        issue(OP_PUSH, 8'd13);
        issue(OP_PUSH, 8'd11);
        @(negedge clk);
        op = OP_MUL;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        // Producer immediately presents the next command and holds it
        op = OP_PUSH;
        din = 8'h55;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_ready) break;
            low++;
        end
        n_cmp++;
        if (low !== 8) begin
            n_bad++;
            $display("FAIL mul_busy_cycles: got %0d expected 8", low);
        end
        n_cmp++;
        if ({top, depth} !== {8'd143, 4'd1}) begin
            n_bad++;
            $display("FAIL mul_result: got top=%0d depth=%0d expected 143 1", top, depth);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        n_cmp++;
        if ({top, second, depth} !== {8'h55, 8'd143, 4'd2}) begin
            n_bad++;
            $display("FAIL mul_held_push: got top=%0h second=%0d depth=%0d expected 55 143 2", top, second, depth);
        end
        $display("mul 13*11: busy=%0d top=%0h second=%0d", low, top, second);
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        issue(OP_POP, 8'd0);          // raises err_unf
        issue(OP_PUSH, 8'd200);
        issue(OP_PUSH, 8'd100);
        issue(OP_ADD, 8'd0);          // carry=1, top=44
        issue(OP_PUSH, 8'd11);
        issue(OP_MUL, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({top, second, depth, carry, err_ovf, err_unf, op_ready} !== {8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid_mul: got top=%0d second=%0d depth=%0d carry=%0d ovf=%0d unf=%0d ready=%0d expected 0 0 0 0 0 0 1",
                     top, second, depth, carry, err_ovf, err_unf, op_ready);
        end
        issue(OP_PUSH, 8'd5);
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({top, depth, op_ready} !== {8'd5, 4'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL mul_aborted: got top=%0d depth=%0d ready=%0d expected 5 1 1", top, depth, op_ready);
        end
        $display("reset mid-mul: depth=%0d top=%0d", depth, top);
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [7:0] d;
        int r;
        logic [7:0] e_top, e_sec;
        for (int i = 0; i < 300; i++) begin
            if (i % 40 == 0) begin
                do_reset();
                model_reset();
            end
            r = $urandom_range(0, 10);
            o = (r >= 8) ? OP_PUSH : 3'(r);
            d = 8'($urandom);
            issue(o, d);
            wait_idle();
            model_op(o, int'(d));
            e_top = (stk.size() > 0) ? 8'(stk[stk.size()-1]) : 8'd0;
            e_sec = (stk.size() > 1) ? 8'(stk[stk.size()-2]) : 8'd0;
            n_cmp++;
            if ({top, second, depth, carry, err_ovf, err_unf} !== {e_top, e_sec, 4'(stk.size()), m_carry, m_ovf, m_unf}) begin
                n_bad++;
                $display("FAIL random[%0d] op=%0d din=%0d: got top=%0d second=%0d depth=%0d c=%0d ovf=%0d unf=%0d expected %0d %0d %0d %0d %0d %0d",
                         i, o, d, top, second, depth, carry, err_ovf, err_unf,
                         e_top, e_sec, stk.size(), m_carry, m_ovf, m_unf);
            end
            $display("random[%0d] op=%0d din=%0d -> top=%0d depth=%0d", i, o, d, top, depth);
        end
    endtask

    task automatic test_no_stall();
        n_cmp++;
        if (n_timeouts !== 0) begin
            n_bad++;
            $display("FAIL handshake_timeout: got %0d stalls expected 0", n_timeouts);
        end
    endtask

    initial begin
        reset = 1'b1;
        op_valid = 1'b0;
        op = 3'd0;
        din = 8'd0;
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_and_or();
        test_underflow();
        test_overflow();
        test_mul_timing();
        test_reset_mid_mul();
        test_random();
        test_no_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rpn_stack_alu.md
Name: rpn_stack_alu

Overview:
- Operand stack and arithmetic core of the RPN calculator; sits directly downstream of the operand/test-data source and consumes its 8-bit data output as push operands.
- Accepts one command per valid/ready handshake: push operand, pop, dup, or binary ops on the top two entries.
- Exposes top-of-stack, second entry, depth and sticky error flags to the display/GPO logic.
- Binary ops are single-cycle, except MUL, which is multi-cycle shift-add.

Parameters:
- DATA_W, 8: operand/stack word width.
- DEPTH, 8: stack entries; must be a power of two, at least 2.
- CNT_W, 4: depth counter width, log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_W  operand for PUSH.
- op_valid  input  1  command present.
- op  input  3  command code.
- op_ready  output  1  core can accept a command.
- top  output  DATA_W  stack[depth-1]; 0 when empty.
- second  output  DATA_W  stack[depth-2]; 0 when depth<2.
- depth  output  CNT_W  entries held, 0..DEPTH.
- carry  output  1  carry/borrow of the last ADD/SUB.
- err_ovf  output  1  sticky overflow flag.
- err_unf  output  1  sticky underflow flag.

Behaviour:
- Reset (sync, active-high, wins over everything):
  - depth=0, top=0, second=0, carry=0, err_ovf=0, err_unf=0, op_ready=1, FSM=IDLE.
  - Stack array contents are don't-care.
- Accept condition: op_valid && op_ready at a rising edge. op and din are sampled only on accept.
- Op codes:
  - 0 PUSH
  - 1 POP
  - 2 ADD
  - 3 SUB
  - 4 AND
  - 5 OR
  - 6 DUP
  - 7 MUL
- Timing:
  - Ops 0-6 complete at the accepting edge.
  - top, second and depth are updated and visible the cycle after the accept.
  - op_ready stays 1 throughout.
- PUSH: stack[depth]=din; depth+1. When depth==DEPTH: no change; err_ovf=1.
- DUP: pushes the current top. Same full rule as PUSH. When depth==0: err_unf=1, no change.
- POP: depth-1. When depth==0: err_unf=1, no change.
- Binary ops (ADD, SUB, AND, OR, MUL):
  - a=second, b=top.
  - Result replaces a; depth-1.
  - When depth<2: err_unf=1, no change; MUL does not start.
- Result widths:
  - ADD: result a+b modulo 2^DATA_W; carry = bit DATA_W of the sum.
  - SUB: result a-b modulo 2^DATA_W; carry = borrow (1 when b>a).
  - Other ops leave carry unchanged.
  - MUL: low DATA_W bits of a*b.
- MUL FSM has two states, IDLE and MUL:
  - IDLE -> MUL on an accepted MUL with depth>=2. Operands are latched; op_ready=0 from the next cycle.
  - In MUL: one shift-add step per cycle; the step counter counts 0..DATA_W-1.
  - On the step DATA_W-1 edge: result written, depth-1, return to IDLE.
  - op_ready is low for exactly DATA_W cycles. The result is visible DATA_W cycles after the accepting edge.
  - op_valid is ignored while op_ready=0. The command is not queued; the producer must hold it.
- Error flags: sticky; cleared only by reset. A faulting op otherwise behaves as a no-op.
- Boundaries:
  - depth==DEPTH: PUSH and DUP rejected.
  - depth==DEPTH-1: PUSH succeeds.
  - Reset during MUL aborts the multiply: depth=0, op_ready=1 the next cycle.
  - No other simultaneous events exist, because the core accepts one op per cycle.

Decomposition:
- Shared package rpn_pkg holds:
  - op-code constants OP_PUSH..OP_MUL (3-bit);
  - FSM state encoding ST_IDLE and ST_MUL;
  - default DATA_W and DEPTH.
- One sub-module, rpn_shift_mul:
  - ports: start, a, b, busy, done, product low DATA_W bits;
  - DATA_W-cycle shift-add.
- The stack array, pointer and flags stay in rpn_stack_alu.

Test Plan:
- Push with ADD: PUSH 3, PUSH 5, ADD -> top=8, depth=1, carry=0.
- Wrap-around with carry: PUSH 200, PUSH 100, ADD -> top=44 (0x2C), carry=1.
- SUB with borrow: PUSH 3, PUSH 5, SUB -> top=0xFE, carry=1.
- AND then OR: PUSH 0xF0, PUSH 0x3C, AND -> top=0x30; PUSH 0x0F, OR -> top=0x3F.
- Underflow: from reset, issue POP, then ADD -> err_unf=1, depth=0. Then PUSH 7 -> top=7, depth=1, err_unf still 1.
- Overflow: PUSH 1..8 -> depth=8, top=8, second=7. PUSH 9 -> depth=8, top=8, err_ovf=1. DUP -> same, no change.
- MUL timing: PUSH 13, PUSH 11, MUL accepted at edge k -> op_ready=0 for edges k+1..k+8; then top=143 (0x8F), depth=1, op_ready=1. A PUSH held during busy is accepted only after op_ready returns.
- Reset mid-MUL: assert reset 3 cycles into MUL -> next cycle depth=0, top=0, op_ready=1, flags 0.
